// File: rtl/div_iter.sv
// Iterative radix-2 restoring divider for DIV/DIVU.
// Produces {remainder, quotient} after DW CALC cycles plus one SIGN cycle and
// holds the result in DONE until the pipeline acknowledges it.
//
// Handshake: start is taken only in IDLE, or in DONE while ack is high (the
// result is consumed and a new op is accepted in the same cycle). done is high
// for exactly the cycles spent in DONE; res is stable while done is high.
// cancel overrides everything and returns the FSM to IDLE on the next edge.
module div_iter #(
  parameter int DW        = 32,
  parameter bit ZERO_FAST = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            sgn,
  input  logic [DW-1:0]   opr1,
  input  logic [DW-1:0]   opr2,
  input  logic            cancel,
  input  logic            ack,
  output logic            stall_req,
  output logic            done,
  output logic [2*DW-1:0] res,
  output logic [1:0]      dbg_state
);

  localparam int CW = $clog2(DW);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_SIGN = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  // {partial remainder (DW+1 bits incl. carry), quotient (DW bits)}
  logic [2*DW:0]     work_q, work_d;
  logic [DW-1:0]     dvsr_q, dvsr_d;
  logic [DW-1:0]     dvnd_q, dvnd_d;   // raw dividend, used for divide-by-zero
  logic              qs_q, qs_d;
  logic              rs_q, rs_d;
  logic              zero_q, zero_d;
  logic              done_q, done_d;
  logic [2*DW-1:0]   res_q, res_d;

  logic              accept;
  logic              a_neg, b_neg;
  logic [DW-1:0]     a_abs, b_abs;
  logic [2*DW:0]     shifted;
  logic [DW:0]       rem_try;
  logic [DW-1:0]     q_fin, r_fin;

  // Operand magnitudes and acceptance of a new divide.
  always_comb begin
    a_neg  = sgn & opr1[DW-1];
    b_neg  = sgn & opr2[DW-1];
    a_abs  = a_neg ? (~opr1 + {{(DW-1){1'b0}}, 1'b1}) : opr1;
    b_abs  = b_neg ? (~opr2 + {{(DW-1){1'b0}}, 1'b1}) : opr2;
    accept = start & ~cancel &
             ((state_q == S_IDLE) | ((state_q == S_DONE) & ack));
  end

  // One restoring step and the final sign fix-up.
  always_comb begin
    shifted = {work_q[2*DW-1:0], 1'b0};
    rem_try = shifted[2*DW:DW];
    q_fin   = work_q[DW-1:0];
    r_fin   = work_q[2*DW-1:DW];
  end

  // Next-state and datapath update.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    work_d  = work_q;
    dvsr_d  = dvsr_q;
    dvnd_d  = dvnd_q;
    qs_d    = qs_q;
    rs_d    = rs_q;
    zero_d  = zero_q;
    done_d  = done_q;
    res_d   = res_q;

    if (cancel) begin
      state_d = S_IDLE;
      done_d  = 1'b0;
    end else if (accept) begin
      work_d = {{(DW+1){1'b0}}, a_abs};
      dvsr_d = b_abs;
      dvnd_d = opr1;
      qs_d   = a_neg ^ b_neg;
      rs_d   = a_neg;
      zero_d = (opr2 == '0);
      cnt_d  = '0;
      if ((opr2 == '0) && ZERO_FAST) begin
        // Divide by zero short-cut: all-ones quotient, raw dividend as remainder.
        res_d   = {opr1, {DW{1'b1}}};
        done_d  = 1'b1;
        state_d = S_DONE;
      end else begin
        done_d  = 1'b0;
        state_d = S_CALC;
      end
    end else begin
      case (state_q)
        S_CALC: begin
          if (rem_try >= {1'b0, dvsr_q}) begin
            work_d = {rem_try - {1'b0, dvsr_q}, shifted[DW-1:1], 1'b1};
          end else begin
            work_d = shifted;
          end
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == CW'(DW-1)) begin
            state_d = S_SIGN;
          end
        end
        S_SIGN: begin
          if (zero_q) begin
            res_d = {dvnd_q, {DW{1'b1}}};
          end else begin
            res_d = {(rs_q ? (~r_fin + {{(DW-1){1'b0}}, 1'b1}) : r_fin),
                     (qs_q ? (~q_fin + {{(DW-1){1'b0}}, 1'b1}) : q_fin)};
          end
          done_d  = 1'b1;
          state_d = S_DONE;
        end
        S_DONE: begin
          if (ack) begin
            done_d  = 1'b0;
            state_d = S_IDLE;
          end
        end
        default: begin
          state_d = state_q;
        end
      endcase
    end
  end

  // State and datapath registers, asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      work_q  <= '0;
      dvsr_q  <= '0;
      dvnd_q  <= '0;
      qs_q    <= 1'b0;
      rs_q    <= 1'b0;
      zero_q  <= 1'b0;
      done_q  <= 1'b0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      work_q  <= work_d;
      dvsr_q  <= dvsr_d;
      dvnd_q  <= dvnd_d;
      qs_q    <= qs_d;
      rs_q    <= rs_d;
      zero_q  <= zero_d;
      done_q  <= done_d;
      res_q   <= res_d;
    end
  end

  // Outputs: stall is combinational so EX holds in the start cycle itself.
  always_comb begin
    stall_req = ~cancel & (((state_q == S_IDLE) & start) |
                           (state_q == S_CALC) | (state_q == S_SIGN));
    done      = done_q;
    res       = res_q;
    dbg_state = state_q;
  end

endmodule
